// File: rtl/bus_gen_arbiter_if.sv
//------------------------------------------------------------------------------
// bus_gen_arbiter_if : device-side bus bundle for the shared-bus arbiter
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bus_gen_arbiter_if #(
    parameter int DRVRS   = 8,
    parameter int PCKG_SZ = 20
);
    logic [DRVRS-1:0]              pndng;
    logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
    logic [DRVRS-1:0]              pop;
    logic [DRVRS-1:0]              push;
    logic [DRVRS-1:0][PCKG_SZ-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

`default_nettype wire

// File: rtl/bus_gen_arbiter.sv
//------------------------------------------------------------------------------
// bus_gen_arbiter : round-robin shared-bus arbiter, pops one device and pushes
//                   to the decoded destination (or all others on broadcast)
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bus_gen_arbiter #(
    parameter int         DRVRS     = 8,
    parameter int         PCKG_SZ   = 20,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input wire logic          clk,
    input wire logic          reset,
    bus_gen_arbiter_if.master bus
);

    localparam int              c_gw       = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam logic [c_gw-1:0] c_last_dev = c_gw'(DRVRS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_gw-1:0]     r_grant;
    logic [c_gw-1:0]     w_grant;
    logic [c_gw-1:0]     r_last;
    logic [DRVRS-1:0]    r_pop;
    logic [DRVRS-1:0]    w_pop;
    logic [DRVRS-1:0]    r_push;
    logic [DRVRS-1:0]    w_push;
    logic [PCKG_SZ-1:0]  r_bus;
    logic [7:0]          w_dest;

    // First requester strictly after the previous grant, wrapping around.
    function automatic logic [c_gw-1:0] rr_pick(
        input logic [DRVRS-1:0] req,
        input logic [c_gw-1:0]  last
    );
        logic [c_gw-1:0] pick;
        logic [c_gw-1:0] idx;
        logic            found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= DRVRS; k++) begin
            idx = c_gw'((int'(last) + k) % DRVRS);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_dest = bus.D_pop[r_grant][PCKG_SZ-1 -: 8];

    always_comb begin
        w_next_state = r_state;
        w_grant      = r_grant;
        w_pop        = '0;
        w_push       = '0;
        case (r_state)
            IDLE: begin
                if (|bus.pndng) begin
                    w_grant        = rr_pick(bus.pndng, r_last);
                    w_pop[w_grant] = 1'b1;
                    w_next_state   = POP;
                end
            end
            POP: begin
                // Push strobes are decoded from the same word being latched.
                w_next_state = PUSH;
                if (w_dest == BROADCAST) begin
                    w_push          = '1;
                    w_push[r_grant] = 1'b0;
                end else if (32'(w_dest) < DRVRS) begin
                    w_push[w_dest[c_gw-1:0]] = 1'b1;
                end
            end
            PUSH:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant <= '0;
            r_last  <= c_last_dev;
            r_pop   <= '0;
            r_push  <= '0;
            r_bus   <= '0;
        end else begin
            r_grant <= w_grant;
            r_pop   <= w_pop;
            r_push  <= w_push;
            if (r_state == POP) begin
                r_bus  <= bus.D_pop[r_grant];
                r_last <= r_grant;
            end
        end
    end

    assign bus.pop    = r_pop;
    assign bus.push   = r_push;
    assign bus.D_push = {DRVRS{r_bus}};

endmodule

`default_nettype wire

// File: tb/tb_bus_gen_arbiter.sv
//------------------------------------------------------------------------------
// tb_bus_gen_arbiter : directed self-checking bench with FIFO device models
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bus_gen_arbiter;

    localparam int DRVRS   = 8;
    localparam int PCKG_SZ = 20;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_gen_arbiter_if #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ)) bus ();

    bus_gen_arbiter #(
        .DRVRS     (DRVRS),
        .PCKG_SZ   (PCKG_SZ),
        .BROADCAST (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [PCKG_SZ-1:0] dev_q [DRVRS][$];
    logic [PCKG_SZ-1:0] exp_q [DRVRS][$];
    int                 dly      [DRVRS];
    int                 push_cnt [DRVRS];
    int                 pop_log  [$];
    int                 rand_dly   = 0;
    int                 inflight   = 0;
    bit                 stress_mon = 1'b0;

    logic [DRVRS-1:0]              s_pop;
    logic [DRVRS-1:0]              s_push;
    logic [DRVRS-1:0][PCKG_SZ-1:0] s_dpush;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_devs();
        for (int i = 0; i < DRVRS; i++) begin
            bus.pndng[i] = (dev_q[i].size() != 0) && (dly[i] == 0);
            bus.D_pop[i] = (dev_q[i].size() != 0) ? dev_q[i][0] : '0;
        end
    endtask

    task automatic send(input int dev, input logic [PCKG_SZ-1:0] pkt);
        dev_q[dev].push_back(pkt);
        drive_devs();
    endtask

    task automatic clear_stats();
        pop_log.delete();
        for (int i = 0; i < DRVRS; i++) push_cnt[i] = 0;
    endtask

    function automatic int push_total();
        int s = 0;
        for (int i = 0; i < DRVRS; i++) s += push_cnt[i];
        return s;
    endfunction

    // Sample outputs mid-cycle, then let devices dequeue just after the edge.
    task automatic cycle();
        @(negedge clk);
        s_pop   = bus.pop;
        s_push  = bus.push;
        s_dpush = bus.D_push;
        chk("pop_push_excl", 64'((|s_pop) && (|s_push)), 64'd0);
        chk("pop_onehot0", 64'($onehot0(s_pop)), 64'd1);
        for (int i = 0; i < DRVRS; i++) begin
            if (s_pop[i]) begin
                pop_log.push_back(i);
                inflight = i;
            end
            if (s_push[i]) push_cnt[i]++;
        end
        if (stress_mon && s_push != '0) begin
            chk("stress_push_mask", 64'(s_push), 64'h04);
            if (exp_q[inflight].size() == 0)
                chk("stress_unexpected", 64'd1, 64'd0);
            else
                chk("stress_data", 64'(s_dpush[2]), 64'(exp_q[inflight].pop_front()));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < DRVRS; i++) begin
            if (s_pop[i] && dev_q[i].size() != 0) begin
                void'(dev_q[i].pop_front());
                dly[i] = int'($urandom_range(rand_dly, 0));
            end else if (dly[i] > 0) begin
                dly[i]--;
            end
        end
        drive_devs();
    endtask

    initial begin
        int guard;
        reset = 1'b0;
        for (int i = 0; i < DRVRS; i++) begin
            dly[i]      = 0;
            push_cnt[i] = 0;
        end
        drive_devs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pop", 64'(bus.pop), 64'd0);
        chk("reset_push", 64'(bus.push), 64'd0);
        chk("reset_dpush", 64'(bus.D_push[3]), 64'd0);
        reset = 1'b1;
        cycle();
        cycle();
        chk("idle_no_pop", 64'(s_pop), 64'd0);

        // Point-to-point: device 1 -> device 2
        send(1, 20'h02008);
        cycle();
        chk("p2p_decide", 64'({s_pop, s_push}), 64'd0);
        cycle();
        chk("p2p_pop", 64'(s_pop), 64'h02);
        chk("p2p_no_push_in_pop", 64'(s_push), 64'd0);
        cycle();
        chk("p2p_push", 64'(s_push), 64'h04);
        chk("p2p_data", 64'(s_dpush[2]), 64'h02008);
        cycle();
        chk("p2p_quiet", 64'({s_pop, s_push}), 64'd0);

        // Broadcast from device 3
        send(3, 20'hFFABC);
        cycle();
        cycle();
        chk("bc_pop", 64'(s_pop), 64'h08);
        cycle();
        chk("bc_push", 64'(s_push), 64'hF7);
        for (int i = 0; i < DRVRS; i++) chk("bc_data", 64'(s_dpush[i]), 64'hFFABC);
        cycle();

        // Invalid destination dropped, following packet serviced normally
        send(4, 20'h09123);
        send(6, 20'h01555);
        cycle();
        cycle();
        chk("inv_pop", 64'(s_pop), 64'h10);
        cycle();
        chk("inv_no_push", 64'(s_push), 64'd0);
        cycle();
        chk("inv_idle", 64'({s_pop, s_push}), 64'd0);
        cycle();
        chk("inv_next_pop", 64'(s_pop), 64'h40);
        cycle();
        chk("inv_next_push", 64'(s_push), 64'h02);
        chk("inv_next_data", 64'(s_dpush[1]), 64'h01555);
        cycle();

        // Asynchronous reset while in POP
        clear_stats();
        send(5, 20'h065A5);
        cycle();
        chk("rst_pre_pop", 64'(bus.pop), 64'h20);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_pop", 64'(bus.pop), 64'd0);
        chk("rst_async_push", 64'(bus.push), 64'd0);
        cycle();
        cycle();
        chk("rst_held", 64'({s_pop, s_push}), 64'd0);
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_after_pop", 64'(s_pop), 64'h20);
        cycle();
        chk("rst_after_push", 64'(s_push), 64'h40);
        chk("rst_after_data", 64'(s_dpush[6]), 64'h065A5);
        cycle();
        cycle();
        chk("rst_push_total", 64'(push_total()), 64'd1);

        // Round-robin fairness from a fresh pointer
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        clear_stats();
        for (int k = 0; k < 2; k++)
            for (int d = 0; d < DRVRS; d++)
                send(d, {8'h00, 12'(d * 16 + k)});
        guard = 0;
        while (push_cnt[0] < 16 && guard < 100) begin
            cycle();
            guard++;
        end
        chk("rr_timeout", 64'(guard < 100), 64'd1);
        if (pop_log.size() >= 16) begin
            for (int k = 0; k < 16; k++) chk("rr_order", 64'(pop_log[k]), 64'(k % DRVRS));
        end else begin
            chk("rr_pop_count", 64'(pop_log.size()), 64'd16);
        end
        chk("rr_push_dev0", 64'(push_cnt[0]), 64'd16);
        chk("rr_push_others", 64'(push_total() - push_cnt[0]), 64'd0);

        // Stress: all other devices to device 2 with random gaps
        clear_stats();
        rand_dly   = 3;
        stress_mon = 1'b1;
        for (int d = 0; d < DRVRS; d++) begin
            if (d != 2) begin
                for (int k = 0; k < 30; k++) begin
                    logic [PCKG_SZ-1:0] pkt;
                    pkt = {8'h02, 12'($urandom)};
                    dev_q[d].push_back(pkt);
                    exp_q[d].push_back(pkt);
                end
                dly[d] = int'($urandom_range(3, 0));
            end
        end
        drive_devs();
        guard = 0;
        while (push_cnt[2] < 210 && guard < 3000) begin
            cycle();
            guard++;
        end
        repeat (6) cycle();
        stress_mon = 1'b0;
        chk("stress_timeout", 64'(guard < 3000), 64'd1);
        chk("stress_push_count", 64'(push_cnt[2]), 64'd210);
        chk("stress_other_push", 64'(push_total() - push_cnt[2]), 64'd0);
        begin
            int left = 0;
            for (int d = 0; d < DRVRS; d++) left += exp_q[d].size();
            chk("stress_leftover", 64'(left), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bus_gen_arbiter.md
Name: bus_gen_arbiter

Overview:
- Shared-bus generator and arbiter connecting `drvrs` FIFO-style devices (drivers).
- Each device presents a pending packet; the block grants the bus round-robin, pops the packet from the source, decodes the 8-bit destination ID in the packet MSBs, and pushes it to the destination device, or to all other devices on broadcast.
- Sits between the per-device FIFO drivers/monitors and the system as the bus fabric under verification.

Parameters:
- drvrs, 8, number of attached devices; device ID = port index 0..drvrs-1 (max 255).
- pckg_sz, 20, packet width in bits (>= 9); [pckg_sz-1:pckg_sz-8] = destination ID, [pckg_sz-9:0] = payload.
- broadcast, 8'hFF, destination ID meaning "deliver to every device except the source".

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pndng  input  [drvrs-1:0]  device i has a packet at the head of its output FIFO.
- D_pop  input  [drvrs-1:0][pckg_sz-1:0]  head packet of device i, valid while pndng[i]=1.
- pop  output  [drvrs-1:0]  one-cycle strobe; device i dequeues its head on that rising edge.
- push  output  [drvrs-1:0]  one-cycle strobe; device i enqueues D_push[i] on that rising edge.
- D_push  output  [drvrs-1:0][pckg_sz-1:0]  packet delivered to each device; all entries carry the same bus value.

Behaviour:
- Reset (reset=0, asynchronous):
  - pop=0, push=0, D_push=0, FSM=IDLE.
  - Round-robin pointer set so device 0 has highest priority.
  - Any in-flight packet is discarded; nothing is pushed for it after reset releases.
- FSM states IDLE, POP, PUSH; registered outputs; one transaction on the bus at a time.
- IDLE:
  - If any pndng bit is 1, select grant g = first i with pndng[i]=1, searching from (last_grant+1) mod drvrs upward with wrap-around.
  - Register g and go to POP.
  - Otherwise stay in IDLE with all strobes 0.
- POP (exactly 1 cycle):
  - pop[g]=1, all other pop bits 0.
  - Latch D_pop[g] into the bus register on the same edge that consumes the FIFO head.
  - Update last_grant=g and go to PUSH.
- PUSH (exactly 1 cycle), with dest = bus[pckg_sz-1:pckg_sz-8]:
  - D_push[i] = bus register for every i.
  - dest == broadcast: push[i]=1 for every i != g.
  - dest < drvrs (including dest == g): push[dest]=1 only.
  - Any other dest (out of range, not broadcast): packet dropped, push stays all zero.
  - Always return to IDLE.
- Throughput: one packet per 3 cycles maximum (IDLE decision, POP, PUSH). A new grant can be made in the IDLE cycle right after PUSH.
- Latency: pndng sampled high in IDLE at edge N → pop visible for the cycle after edge N → push visible one cycle later.
- pop and push are never both asserted in the same cycle.
- At most one pop bit is asserted at any time.
- D_push holds its last value outside PUSH (don't care); checkers must qualify D_push with push.
- pndng dropping during POP is a device protocol violation; the latched data is still delivered.
- Payload bits are transported unmodified. The destination field is not rewritten, so broadcast packets arrive with ID 8'hFF.
- Fairness: a device with pndng held high is granted within drvrs transactions.

Test Plan:
- Point-to-point: drvrs=8, pckg_sz=20; device 1 presents 20'h02_008 → pop[1] for 1 cycle, next cycle push=8'b0000_0100 with D_push[2]=20'h02008; no other strobes.
- Broadcast: device 3 presents 20'hFF_ABC → pop[3], then push=8'b1111_0111, all D_push=20'hFFABC.
- Round-robin fairness: all 8 devices hold pndng with dest=0 → pop order 0,1,2,…,7,0; each device gets exactly one grant per 8 transactions; device 0 receives all 8 pushes.
- Invalid destination: device 4 sends 20'h09_123 → pop[4] asserted, push stays 0, next packet is serviced normally.
- Reset mid-operation: assert reset=0 asynchronously while in POP → pop and push go 0 immediately without waiting for a clock; no push after release. After release, a pending device 5 with dest 6 is serviced normally (pop[5], then push[6]).
- Stress, all devices to one target: each device sends 30 random-payload packets to device 2 with random pndng delays → exactly 210 pushes on push[2], payloads match in per-source order, no packet lost or duplicated.
